// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl: drives the up/down/clear command pair of the 0-999
// display counter from run ticks, two auto-repeat buttons and a clear.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_tick           one-cycle base-rate pulse (run and repeat time base)
//   i_run, i_run_dir run enable; direction 0 = up, 1 = down
//   i_btn_up/down    debounced user buttons (levels)
//   i_clear          one-cycle clear request
//   i_count          counter value, only used when SATURATE_EN is defined
//   o_up, o_down     registered command pulses, {1,1} = clear
//   o_state          FSM state (IDLE=0 RUN=1 PRESS=2 HOLD=3 REPEAT=4)
//   o_busy           1 while a button is being handled
//
// Build option: define SATURATE_EN to suppress up steps at 999 and down
// steps at 0 instead of letting the counter wrap.

module counter_step_ctrl #(
  parameter int unsigned HOLD_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_run_dir,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_clear,
  input  logic [9:0] i_count,
  output logic       o_up,
  output logic       o_down,
  output logic [2:0] o_state,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PRESS  = 3'd2,
    S_HOLD   = 3'd3,
    S_REPEAT = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_DELAY);
  localparam logic [7:0] RPT_LD  = 8'(REPEAT_PERIOD);

  state_t     state;
  logic       btn_up_q;
  logic       btn_dn_q;
  logic       btn_sel;
  logic [7:0] rpt_cnt;

  logic rise_up;
  logic rise_dn;
  logic press_up;
  logic press_dn;
  logic press;
  logic held;
  logic other_rise;
  logic abort;
  logic cnt_last;
  logic can_up;
  logic can_dn;

  assign rise_up  = i_btn_up & ~btn_up_q;
  assign rise_dn  = i_btn_down & ~btn_dn_q;

  // A rise only counts while the other button is low, so a
  // simultaneous rise of both buttons is never a press.
  assign press_up = rise_up & ~i_btn_down;
  assign press_dn = rise_dn & ~i_btn_up;
  assign press    = press_up | press_dn;

  assign held       = btn_sel ? i_btn_down : i_btn_up;
  assign other_rise = btn_sel ? rise_up : rise_dn;
  assign abort      = ~held | other_rise;
  assign cnt_last   = (rpt_cnt == 8'd1);

`ifdef SATURATE_EN
  assign can_up = (i_count != 10'd999);
  assign can_dn = (i_count != 10'd0);
`else
  logic unused_count;
  assign unused_count = ^i_count;
  assign can_up = 1'b1;
  assign can_dn = 1'b1;
`endif

  // {up, down} command for one step; a blocked step yields 00.
  function automatic logic [1:0] step_cmd(input logic dn);
    step_cmd = dn ? {1'b0, can_dn} : {can_up, 1'b0};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_up     <= 1'b0;
      o_down   <= 1'b0;
      btn_up_q <= 1'b1;
      btn_dn_q <= 1'b1;
      btn_sel  <= 1'b0;
      rpt_cnt  <= 8'd0;
    end else begin
      btn_up_q <= i_btn_up;
      btn_dn_q <= i_btn_down;
      o_up     <= 1'b0;
      o_down   <= 1'b0;
      if (i_clear) begin
        o_up   <= 1'b1;
        o_down <= 1'b1;
        state  <= S_IDLE;
      end else if (press) begin
        btn_sel <= press_dn;
        state   <= S_PRESS;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (i_run) state <= S_RUN;
          end
          S_RUN: begin
            if (!i_run) begin
              state <= S_IDLE;
            end else if (i_tick) begin
              {o_up, o_down} <= step_cmd(i_run_dir);
            end
          end
          S_PRESS: begin
            {o_up, o_down} <= step_cmd(btn_sel);
            rpt_cnt        <= HOLD_LD;
            state          <= S_HOLD;
          end
          S_HOLD, S_REPEAT: begin
            if (abort) begin
              state <= S_IDLE;
            end else if (i_tick) begin
              if (cnt_last) begin
                {o_up, o_down} <= step_cmd(btn_sel);
                rpt_cnt        <= RPT_LD;
                state          <= S_REPEAT;
              end else begin
                rpt_cnt <= rpt_cnt - 8'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_state = state;
  assign o_busy  = (state == S_PRESS) |
                   (state == S_HOLD) |
                   (state == S_REPEAT);

endmodule

// File: tb/tb_counter_step_ctrl.sv
// tb_counter_step_ctrl: directed and random stimulus for counter_step_ctrl
// checked cycle by cycle against a tick-counting reference model.

module tb_counter_step_ctrl;

  localparam int HD = 8;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       run;
  logic       run_dir;
  logic       btn_up;
  logic       btn_dn;
  logic       clear;
  logic [9:0] count;
  logic       o_up;
  logic       o_down;
  logic [2:0] o_state;
  logic       o_busy;

  always #5 clk = ~clk;

  counter_step_ctrl #(
    .HOLD_DELAY   (HD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tick    (tick),
    .i_run     (run),
    .i_run_dir (run_dir),
    .i_btn_up  (btn_up),
    .i_btn_down(btn_dn),
    .i_clear   (clear),
    .i_count   (count),
    .o_up      (o_up),
    .o_down    (o_down),
    .o_state   (o_state),
    .o_busy    (o_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 press, 3 hold, 4 repeat.
  // Hold/repeat timing is derived from the number of ticks seen since
  // the press: step when ticks == HD, then every RP ticks after that.
  int m_mode;
  int m_ticks;
  bit m_btn;
  bit m_pu;
  bit m_pd;
  bit e_up;
  bit e_dn;

  function automatic void m_step(bit dn);
`ifdef SATURATE_EN
    if (dn) e_dn = (count != 10'd0);
    else    e_up = (count != 10'd999);
`else
    e_dn = dn;
    e_up = !dn;
`endif
  endfunction

  task automatic model_cycle();
    bit ru, rd, pu, pd, held, orise;
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_btn = 0;
      m_pu = 1; m_pd = 1; e_up = 0; e_dn = 0;
      return;
    end
    ru = btn_up && !m_pu;
    rd = btn_dn && !m_pd;
    pu = ru && !btn_dn;
    pd = rd && !btn_up;
    held  = m_btn ? btn_dn : btn_up;
    orise = m_btn ? ru : rd;
    m_pu = btn_up;
    m_pd = btn_dn;
    e_up = 0;
    e_dn = 0;
    if (clear) begin
      e_up = 1; e_dn = 1; m_mode = 0;
    end else if (pu || pd) begin
      m_btn = pd; m_mode = 2;
    end else begin
      case (m_mode)
        0: if (run) m_mode = 1;
        1: begin
          if (!run) m_mode = 0;
          else if (tick) m_step(run_dir);
        end
        2: begin
          m_step(m_btn); m_ticks = 0; m_mode = 3;
        end
        3, 4: begin
          if (!held || orise) m_mode = 0;
          else if (tick) begin
            m_ticks++;
            if (m_ticks >= HD && ((m_ticks - HD) % RP) == 0) begin
              m_step(m_btn);
              m_mode = 4;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic chk(string tag);
    logic [2:0] es;
    logic       eb;
    es = 3'(m_mode);
    eb = (m_mode >= 2 && m_mode <= 4);
    checks++;
    assert (o_up === e_up) else begin
      errors++;
      $error("FAIL %s o_up got %b exp %b", tag, o_up, e_up);
    end
    checks++;
    assert (o_down === e_dn) else begin
      errors++;
      $error("FAIL %s o_down got %b exp %b", tag, o_down, e_dn);
    end
    checks++;
    assert (o_state === es) else begin
      errors++;
      $error("FAIL %s o_state got %0d exp %0d", tag, o_state, es);
    end
    checks++;
    assert (o_busy === eb) else begin
      errors++;
      $error("FAIL %s o_busy got %b exp %b", tag, o_busy, eb);
    end
  endtask

  task automatic cyc(int n, string tag);
    repeat (n) begin
      model_cycle();
      @(posedge clk);
      #1;
      chk(tag);
    end
  endtask

  initial begin
    rst = 1; tick = 0; run = 0; run_dir = 0;
    btn_up = 1; btn_dn = 0; clear = 0; count = 10'd500;
    cyc(3, "reset");
    rst = 0;
    cyc(4, "held_thru_rst");
    btn_up = 0;
    cyc(2, "held_release");
    btn_up = 1; tick = 1;
    cyc(3, "repress");
    btn_up = 0; tick = 0;
    cyc(3, "repress_rel");

    run = 1; run_dir = 0;
    for (int i = 0; i < 24; i++) begin
      tick = (i % 4 == 0);
      cyc(1, "run_up");
    end
    tick = 0; run = 0;
    cyc(2, "run_stop");

    tick = 1; btn_up = 1;
    cyc(30, "hold_up");
    btn_up = 0;
    cyc(4, "hold_up_rel");
    tick = 0;

    btn_dn = 1; tick = 1;
    cyc(5, "hold_dn");
    btn_up = 1;
    cyc(4, "abort");
    btn_up = 0;
    cyc(2, "abort_rel");
    btn_up = 1;
    cyc(3, "no_press");
    btn_up = 0; btn_dn = 0; tick = 0;
    cyc(3, "idle");

    run = 1;
    cyc(3, "pre_clear");
    clear = 1; btn_up = 1; tick = 1;
    cyc(1, "clear");
    clear = 0; tick = 0;
    cyc(3, "after_clear");
    btn_up = 0; run = 0;
    cyc(3, "clear_done");

    count = 10'd999; btn_up = 1; tick = 1;
    cyc(3, "sat_up");
    btn_up = 0; tick = 0;
    cyc(2, "sat_up_rel");
    count = 10'd0; run = 1; run_dir = 1;
    cyc(2, "sat_run");
    tick = 1;
    cyc(1, "sat_dn_tick");
    tick = 0;
    cyc(2, "sat_dn");
    run = 0; run_dir = 0; count = 10'd500;
    cyc(2, "sat_done");

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) run_dir = ~run_dir;
      if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 11) == 0) btn_dn = ~btn_dn;
      case ($urandom_range(0, 3))
        0:       count = 10'd0;
        1:       count = 10'd999;
        default: count = 10'($urandom_range(1, 998));
      endcase
      cyc(1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_step_ctrl.md
Name: counter_step_ctrl

Overview:
Sequencer that drives the up/down/clear command pair of the 0-999 display counter in the clock design. It shares the counter between two sources: a free-running tick source for run mode (stopwatch up or timer down) and two user adjust buttons with press-and-hold auto-repeat. It also provides a clear command. Outputs are registered single-cycle command pulses that connect directly to the counter's i_up/i_down inputs, where {1,1} means clear.

Parameters:
HOLD_DELAY, 8, number of i_tick pulses a button must stay held after the first step before auto-repeat starts (legal range 1..255)
REPEAT_PERIOD, 2, number of i_tick pulses between auto-repeat steps (legal range 1..255)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_tick  input  1  one-cycle base-rate pulse; the time base for run mode and auto-repeat
i_run  input  1  level; 1 = run mode enabled
i_run_dir  input  1  run direction; 0 = step up per tick, 1 = step down per tick
i_btn_up  input  1  debounced level, user increment button
i_btn_down  input  1  debounced level, user decrement button
i_clear  input  1  one-cycle clear request
i_count  input  10  current counter value; used only with SATURATE_EN
o_up  output  1  counter up command (registered)
o_down  output  1  counter down command (registered)
o_state  output  3  current FSM state encoding
o_busy  output  1  1 while in PRESS, HOLD or REPEAT

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst). All state updates happen on the rising edge of i_clk.
- Reset values: o_up=0, o_down=0, o_state=IDLE(0), o_busy=0, repeat counter=0. The button-history registers reset to 1, so a button held through reset must be released before it counts as a press.
- States and encodings: IDLE=0, RUN=1, PRESS=2, HOLD=3, REPEAT=4. Encodings 5..7 are illegal and recover to IDLE on the next cycle.
- Press detection: a rising edge of one button while the other button is low. A simultaneous rise of both buttons is ignored.
- A step is a one-cycle pulse on o_up or o_down, registered, and appears in the cycle after the decision. o_up=o_down=1 occurs only for clear.
- Priority, highest first: i_clear, then button press, then release/abort, then tick.
- i_clear, in any state: next cycle o_up=o_down=1 for exactly one cycle; the state goes to IDLE. Any press or tick in the same cycle is dropped.
- IDLE:
  - press -> PRESS
  - else if i_run=1 -> RUN
  - no steps are issued
- RUN:
  - on each i_tick, step in direction i_run_dir
  - i_run=0 -> IDLE
  - press -> PRESS; a coincident tick is dropped
- PRESS (one cycle):
  - issue one step in the pressed button's direction
  - latch the button identity
  - load the counter with HOLD_DELAY
  - -> HOLD
- HOLD:
  - each i_tick decrements the counter
  - when a tick arrives with counter=1: issue a step, load REPEAT_PERIOD, go to REPEAT
- REPEAT:
  - each i_tick decrements the counter
  - at counter=1 on a tick: issue a step and reload REPEAT_PERIOD
- Release/abort, in HOLD or REPEAT:
  - the latched button going low, or the other button going high -> IDLE with no step
  - re-entry to RUN then follows the IDLE rule
- o_busy is combinational from the state (1 in PRESS, HOLD, REPEAT).
- Run mode is suspended while a button is being handled; run ticks that arrive during PRESS, HOLD or REPEAT are lost.
- Wrap-around at 999->0 and 0->999 belongs to the counter; this block does not track the value unless SATURATE_EN is defined.

Optional Feature:
SATURATE_EN
- Defined: an up step is suppressed (outputs stay 00) when i_count==999, and a down step is suppressed when i_count==0, from every source (run, press, repeat). Counter reload and state transitions proceed as if the step had been issued. Clear is unaffected.
- Not defined: i_count is ignored and all steps are issued, so the counter wraps.

Test Plan:
- Reset, then i_run=1, i_run_dir=0, i_tick every 4 cycles -> state RUN; one o_up pulse one cycle after each tick; o_down stays 0.
- i_btn_up rises and is held with i_tick every cycle (defaults) -> o_up one cycle after PRESS; next o_up 8 ticks later; then o_up every 2 ticks until release; release -> IDLE with no further pulses.
- i_btn_down held, then i_btn_up raised during HOLD -> IDLE with no step. Raising i_btn_up again while i_btn_down is still high -> no press.
- i_clear in the same cycle as a button rise and a tick in RUN -> exactly one cycle of o_up=o_down=1; state IDLE, then RUN.
- Hold i_btn_up through reset deassertion -> no step until the button is released and pressed again.
- With SATURATE_EN: i_count=999 and i_btn_up pressed -> no o_up, state still PRESS->HOLD. i_count=0, i_run_dir=1, tick -> no o_down. Without the macro, the same stimulus produces the pulses.
